// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-side types and constants for the IF2/ID instruction buffer
package fetch_pkg;

  localparam int BRTYPE_W    = 2;
  localparam int FETCH_WIDTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [33:0] brtype_pcpre;
  } fetch_entry_t;

  function automatic logic [1:0] pop2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/inst_buf_ram.sv
// rtl/inst_buf_ram.sv - DEPTH-entry fetch entry array, two write ports, two async read ports
module inst_buf_ram
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we0,
  input  logic [PTR_W-1:0]   waddr0,
  input  fetch_entry_t       wdata0,
  input  logic               we1,
  input  logic [PTR_W-1:0]   waddr1,
  input  fetch_entry_t       wdata1,
  input  logic [PTR_W-1:0]   raddr0,
  output fetch_entry_t       rdata0,
  input  logic [PTR_W-1:0]   raddr1,
  output fetch_entry_t       rdata1
);

  fetch_entry_t mem [DEPTH];

  // Write addresses are always distinct (consecutive slots), so port order is irrelevant.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/if_inst_buffer.sv
// rtl/if_inst_buffer.sv - dual-issue decoupling instruction queue between IF2 and ID; optional INST_BUF_PERF_EN adds perf counters
module if_inst_buffer
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] i_PC1,
  input  logic [31:0] i_PC2,
  input  logic [31:0] i_inst1,
  input  logic [31:0] i_inst2,
  input  logic [33:0] i_brtype_pcpre_1,
  input  logic [33:0] i_brtype_pcpre_2,
  input  logic [1:0]  i_is_valid,
  input  logic        flush_BR,
  input  logic        i_id_ready,
  output logic [31:0] o_PC1,
  output logic [31:0] o_PC2,
  output logic [31:0] o_inst1,
  output logic [31:0] o_inst2,
  output logic [33:0] o_brtype_pcpre_1,
  output logic [33:0] o_brtype_pcpre_2,
  output logic [1:0]  o_is_valid,
`ifdef INST_BUF_PERF_EN
  output logic [31:0] o_perf_full_cyc,
  output logic [31:0] o_perf_empty_cyc,
`endif
  output logic        o_buf_full
);

  localparam logic [PTR_W:0] FULL_AT = (PTR_W+1)'(DEPTH - 1);

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count, count_next;
  logic             push_ok;
  logic [1:0]       pushed, popped;
  fetch_entry_t     slot1, slot2, head0, head1;

  assign slot1 = '{pc: i_PC1, inst: i_inst1, brtype_pcpre: i_brtype_pcpre_1};
  assign slot2 = '{pc: i_PC2, inst: i_inst2, brtype_pcpre: i_brtype_pcpre_2};

  assign o_buf_full = (count >= FULL_AT);
  assign o_is_valid = (count >= (PTR_W+1)'(2)) ? 2'b11 :
                      (count == (PTR_W+1)'(1)) ? 2'b01 : 2'b00;

  assign push_ok    = (i_is_valid != 2'b00) && !o_buf_full;
  assign pushed     = push_ok ? pop2(i_is_valid) : 2'b00;
  assign popped     = i_id_ready ? pop2(o_is_valid) : 2'b00;
  assign count_next = count + (PTR_W+1)'(pushed) - (PTR_W+1)'(popped);

  // A lone slot-2 instruction is compacted into the wr_ptr position.
  inst_buf_ram #(.DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .we0    (push_ok),
    .waddr0 (wr_ptr),
    .wdata0 (i_is_valid[0] ? slot1 : slot2),
    .we1    (push_ok && (i_is_valid == 2'b11)),
    .waddr1 (wr_ptr + 1'b1),
    .wdata1 (slot2),
    .raddr0 (rd_ptr),
    .rdata0 (head0),
    .raddr1 (rd_ptr + 1'b1),
    .rdata1 (head1)
  );

  assign o_PC1            = head0.pc;
  assign o_inst1          = head0.inst;
  assign o_brtype_pcpre_1 = head0.brtype_pcpre;
  assign o_PC2            = head1.pc;
  assign o_inst2          = head1.inst;
  assign o_brtype_pcpre_2 = head1.brtype_pcpre;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_BR) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(popped);
      wr_ptr <= wr_ptr + PTR_W'(pushed);
      count  <= count_next;
    end
  end

`ifdef INST_BUF_PERF_EN
  // Perf counters survive branch flushes; only reset clears them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_perf_full_cyc  <= '0;
      o_perf_empty_cyc <= '0;
    end else begin
      if (o_buf_full && (i_is_valid != 2'b00) && (o_perf_full_cyc != 32'hFFFF_FFFF))
        o_perf_full_cyc <= o_perf_full_cyc + 32'd1;
      if ((count == '0) && i_id_ready && (o_perf_empty_cyc != 32'hFFFF_FFFF))
        o_perf_empty_cyc <= o_perf_empty_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_inst_buffer.sv
// tb/tb_if_inst_buffer.sv - directed self-checking bench for if_inst_buffer
module tb_if_inst_buffer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] i_PC1, i_PC2, i_inst1, i_inst2;
  logic [33:0] i_brtype_pcpre_1, i_brtype_pcpre_2;
  logic [1:0]  i_is_valid;
  logic        flush_BR, i_id_ready;
  logic [31:0] o_PC1, o_PC2, o_inst1, o_inst2;
  logic [33:0] o_brtype_pcpre_1, o_brtype_pcpre_2;
  logic [1:0]  o_is_valid;
  logic        o_buf_full;
`ifdef INST_BUF_PERF_EN
  logic [31:0] o_perf_full_cyc, o_perf_empty_cyc;
`endif

  int tests = 0;
  int failed = 0;

  if_inst_buffer #(.DEPTH(8)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .i_PC1            (i_PC1),
    .i_PC2            (i_PC2),
    .i_inst1          (i_inst1),
    .i_inst2          (i_inst2),
    .i_brtype_pcpre_1 (i_brtype_pcpre_1),
    .i_brtype_pcpre_2 (i_brtype_pcpre_2),
    .i_is_valid       (i_is_valid),
    .flush_BR         (flush_BR),
    .i_id_ready       (i_id_ready),
    .o_PC1            (o_PC1),
    .o_PC2            (o_PC2),
    .o_inst1          (o_inst1),
    .o_inst2          (o_inst2),
    .o_brtype_pcpre_1 (o_brtype_pcpre_1),
    .o_brtype_pcpre_2 (o_brtype_pcpre_2),
    .o_is_valid       (o_is_valid),
`ifdef INST_BUF_PERF_EN
    .o_perf_full_cyc  (o_perf_full_cyc),
    .o_perf_empty_cyc (o_perf_empty_cyc),
`endif
    .o_buf_full       (o_buf_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle 1ns after the edge.
  task automatic step(input logic [1:0] v, input logic [31:0] pc1, input logic [31:0] pc2,
                      input logic rdy, input logic fl);
    i_is_valid       = v;
    i_PC1            = pc1;
    i_PC2            = pc2;
    i_inst1          = pc1 ^ 32'hFFFF_0000;
    i_inst2          = pc2 ^ 32'hFFFF_0000;
    i_brtype_pcpre_1 = {2'b01, pc1 + 32'h10};
    i_brtype_pcpre_2 = {2'b10, pc2 + 32'h20};
    i_id_ready       = rdy;
    flush_BR         = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    i_is_valid = 2'b00; i_PC1 = '0; i_PC2 = '0; i_inst1 = '0; i_inst2 = '0;
    i_brtype_pcpre_1 = '0; i_brtype_pcpre_2 = '0; flush_BR = 1'b0; i_id_ready = 1'b0;
    #1;
    chk("reset_valid", o_is_valid, 2'b00);
    chk("reset_full", o_buf_full, 1'b0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Basic pair push, 1-cycle latency
    step(2'b11, 32'h1c000000, 32'h1c000004, 1'b0, 1'b0);
    chk("pair_valid", o_is_valid, 2'b11);
    chk("pair_pc1", o_PC1, 32'h1c000000);
    chk("pair_pc2", o_PC2, 32'h1c000004);
    chk("pair_inst1", o_inst1, 32'he3ff0000);
    chk("pair_br2", o_brtype_pcpre_2, {2'b10, 32'h1c000024});
    step(2'b00, 0, 0, 1'b1, 1'b0);
    chk("pair_drained", o_is_valid, 2'b00);

    // Single-slot compaction: 01 then 10
    step(2'b01, 32'h100, 32'hdead, 1'b0, 1'b0);
    chk("c01_valid", o_is_valid, 2'b01);
    chk("c01_pc1", o_PC1, 32'h100);
    step(2'b10, 32'hbeef, 32'h108, 1'b0, 1'b0);
    chk("c10_valid", o_is_valid, 2'b11);
    chk("c10_pc1", o_PC1, 32'h100);
    chk("c10_pc2", o_PC2, 32'h108);
    chk("c10_inst2", o_inst2, 32'hffff0108);
    step(2'b00, 0, 0, 1'b1, 1'b0);
    chk("c_drained", o_is_valid, 2'b00);

    // Fill to DEPTH, dropped fifth push, ordered drain
    for (int k = 0; k < 4; k++) begin
      chk("fill_notfull", o_buf_full, 1'b0);
      step(2'b11, 32'h200 + 32'(8*k), 32'h204 + 32'(8*k), 1'b0, 1'b0);
    end
    chk("fill_full", o_buf_full, 1'b1);
    step(2'b11, 32'hbad0, 32'hbad4, 1'b0, 1'b0);
    chk("fill_drop_full", o_buf_full, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", o_is_valid, 2'b11);
      chk("drain_pc1", o_PC1, 32'h200 + 32'(8*k));
      chk("drain_pc2", o_PC2, 32'h204 + 32'(8*k));
      step(2'b00, 0, 0, 1'b1, 1'b0);
    end
    chk("drain_empty", o_is_valid, 2'b00);
    chk("drain_notfull", o_buf_full, 1'b0);

    // Count 7 boundary: full asserts, push dropped, pop clears full
    step(2'b11, 32'h400, 32'h404, 1'b0, 1'b0);
    step(2'b11, 32'h408, 32'h40c, 1'b0, 1'b0);
    step(2'b11, 32'h410, 32'h414, 1'b0, 1'b0);
    chk("c6_notfull", o_buf_full, 1'b0);
    step(2'b01, 32'h418, 32'h0, 1'b0, 1'b0);
    chk("c7_full", o_buf_full, 1'b1);
    step(2'b11, 32'hbad8, 32'hbadc, 1'b0, 1'b0);
    chk("c7_still_full", o_buf_full, 1'b1);
    step(2'b00, 0, 0, 1'b1, 1'b0);
    chk("c5_notfull", o_buf_full, 1'b0);
    chk("c5_pc1", o_PC1, 32'h408);
    step(2'b00, 0, 0, 1'b1, 1'b0);
    chk("c3_pc1", o_PC1, 32'h410);
    step(2'b00, 0, 0, 1'b1, 1'b0);
    chk("c1_valid", o_is_valid, 2'b01);
    chk("c1_pc1", o_PC1, 32'h418);
    step(2'b00, 0, 0, 1'b1, 1'b0);
    chk("c0_valid", o_is_valid, 2'b00);
    step(2'b00, 0, 0, 1'b1, 1'b0);
    chk("idle_pop_noop", o_is_valid, 2'b00);

    // Streaming push/pop with pointer wrap
    step(2'b11, 32'h1000, 32'h1004, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      chk("stream_valid", o_is_valid, 2'b11);
      chk("stream_full", o_buf_full, 1'b0);
      chk("stream_pc1", o_PC1, 32'h1000 + 32'(8*k));
      chk("stream_pc2", o_PC2, 32'h1004 + 32'(8*k));
      step(2'b11, 32'h1000 + 32'(8*(k+1)), 32'h1004 + 32'(8*(k+1)), 1'b1, 1'b0);
    end
    chk("stream_last_pc1", o_PC1, 32'h10a0);
    step(2'b00, 0, 0, 1'b1, 1'b0);
    chk("stream_empty", o_is_valid, 2'b00);

    // Flush wins over simultaneous push and pop at count 5
    step(2'b11, 32'h2000, 32'h2004, 1'b0, 1'b0);
    step(2'b11, 32'h2008, 32'h200c, 1'b0, 1'b0);
    step(2'b01, 32'h2010, 32'h0, 1'b0, 1'b0);
    chk("pre_flush_valid", o_is_valid, 2'b11);
    step(2'b11, 32'h2f00, 32'h2f04, 1'b1, 1'b1);
    chk("flush_valid", o_is_valid, 2'b00);
    chk("flush_full", o_buf_full, 1'b0);
    step(2'b00, 0, 0, 1'b0, 1'b0);
    chk("flush_hold", o_is_valid, 2'b00);
    step(2'b01, 32'h3000, 32'h0, 1'b0, 1'b0);
    chk("post_flush_valid", o_is_valid, 2'b01);
    chk("post_flush_pc1", o_PC1, 32'h3000);
    step(2'b00, 0, 0, 1'b1, 1'b0);

    // Asynchronous reset mid-burst at count 6
    step(2'b11, 32'h4000, 32'h4004, 1'b0, 1'b0);
    step(2'b11, 32'h4008, 32'h400c, 1'b0, 1'b0);
    step(2'b11, 32'h4010, 32'h4014, 1'b0, 1'b0);
    chk("pre_rst_valid", o_is_valid, 2'b11);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_valid", o_is_valid, 2'b00);
    chk("async_rst_full", o_buf_full, 1'b0);
    @(posedge clk);
    #1 rstn = 1'b1;
    step(2'b00, 0, 0, 1'b0, 1'b0);
    chk("after_rst_valid", o_is_valid, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
